// File: rtl/udp_tx_pkg.sv
// UDP TX encapsulation: shared state enum, constants and header byte helper.
// Optional length checking in the top is enabled by UDP_TX_LEN_CHECK_EN.
package udp_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD
  } udp_tx_state_t;

  localparam int UDP_HDR_BYTES = 8;
  localparam int IP_PROTO_UDP  = 17;

  function automatic logic [7:0] udp_hdr_byte(
    input logic [2:0]  idx,
    input logic [15:0] src,
    input logic [15:0] dst,
    input logic [15:0] len,
    input logic [15:0] cks
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = src[15:8];
      3'd1:    b = src[7:0];
      3'd2:    b = dst[15:8];
      3'd3:    b = dst[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      3'd6:    b = cks[15:8];
      default: b = cks[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_header_inserter.sv
// Serializes an 8-byte UDP header ahead of the payload beat stream.
// Define UDP_TX_LEN_CHECK_EN to build the payload length checker (len_err).
module udp_header_inserter
  import udp_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IDX_W      = $clog2(DATA_WIDTH/8+1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [15:0]           src_port,
  input  logic [15:0]           dst_port,
  input  logic [15:0]           udp_length,
  input  logic [15:0]           udp_checksum,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [IDX_W-1:0]      s_idx,
  input  logic                  s_last,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [IDX_W-1:0]      m_idx,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  len_err
);

  localparam int NB = DATA_WIDTH/8;
  localparam int HB = UDP_HDR_BYTES/NB;
  localparam logic [1:0] HB_L = 2'(HB);
  localparam logic [1:0] HB_M1 = 2'(HB-1);
  localparam logic [IDX_W-1:0] NB_L = IDX_W'(NB);

  udp_tx_state_t r_state, w_next;

  logic [15:0] r_src, r_dst, r_len, r_cks;
  logic [1:0]  r_hcnt;

  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [IDX_W-1:0]      r_m_idx;
  logic                  r_m_last;
  logic                  r_m_valid;

  logic                  w_free, w_idle, w_hdr;
  logic                  w_hdr_acc, w_hdr_done;
  logic                  w_hdr_load, w_hdr_last;
  logic                  w_pay_ok, w_s_acc;
  logic [1:0]            w_beat_k;
  logic [15:0]           w_src, w_dst, w_len, w_cks;
  logic [DATA_WIDTH-1:0] w_hdr_beat;

  assign w_idle = (r_state == ST_IDLE);
  assign w_hdr  = (r_state == ST_HDR);
  assign w_free = !r_m_valid || m_ready;

  assign hdr_ready = w_idle;
  assign w_hdr_acc = hdr_valid && w_idle;
  assign w_hdr_done = (r_hcnt == HB_L);

  // The first header beat is built straight from the descriptor inputs
  assign w_src = w_idle ? src_port     : r_src;
  assign w_dst = w_idle ? dst_port     : r_dst;
  assign w_len = w_idle ? udp_length   : r_len;
  assign w_cks = w_idle ? udp_checksum : r_cks;
  assign w_beat_k = w_idle ? 2'd0 : r_hcnt;

  assign w_hdr_load = w_free &&
    ((w_hdr_acc) || (w_hdr && !w_hdr_done));
  assign w_hdr_last = (w_beat_k == HB_M1) &&
    (w_len <= 16'd8);

  // Payload may start as soon as the header is loaded
  assign w_pay_ok = (r_state == ST_PAYLOAD) ||
    (w_hdr && w_hdr_done && (r_len > 16'd8));
  assign s_ready = w_pay_ok && w_free;
  assign w_s_acc = s_valid && s_ready;

  always_comb begin
    w_hdr_beat = '0;
    for (int i = 0; i < NB; i++)
      w_hdr_beat[i*8 +: 8] = udp_hdr_byte(
        3'(int'(w_beat_k) * NB + i),
        w_src, w_dst, w_len, w_cks);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (hdr_valid) w_next = ST_HDR;
      ST_HDR:
        if (w_hdr_done) begin
          if (r_len <= 16'd8) w_next = ST_IDLE;
          else if (w_s_acc && s_last) w_next = ST_IDLE;
          else w_next = ST_PAYLOAD;
        end
      ST_PAYLOAD:
        if (w_s_acc && s_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_cks   <= '0;
      r_hcnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_hdr_acc) begin
        r_src  <= src_port;
        r_dst  <= dst_port;
        r_len  <= udp_length;
        r_cks  <= udp_checksum;
        r_hcnt <= w_free ? 2'd1 : 2'd0;
      end else if (w_hdr && w_hdr_load) begin
        r_hcnt <= r_hcnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_tdata <= '0;
      r_m_idx   <= '0;
      r_m_last  <= 1'b0;
    end else if (w_hdr_load) begin
      r_m_valid <= 1'b1;
      r_m_tdata <= w_hdr_beat;
      r_m_idx   <= NB_L;
      r_m_last  <= w_hdr_last;
    end else if (w_s_acc) begin
      r_m_valid <= 1'b1;
      r_m_tdata <= s_tdata;
      r_m_idx   <= s_idx;
      r_m_last  <= s_last;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_tdata = r_m_tdata;
  assign m_idx   = r_m_idx;
  assign m_last  = r_m_last;

`ifdef UDP_TX_LEN_CHECK_EN
  logic [15:0] r_pay_cnt;
  logic        r_len_err;
  logic [16:0] w_sum;
  logic [15:0] w_tot;

  assign w_sum = {1'b0, r_pay_cnt} + 17'(s_idx);
  assign w_tot = w_sum[16] ? 16'hFFFF : w_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pay_cnt <= '0;
      r_len_err <= 1'b0;
    end else if (w_hdr_acc) begin
      r_pay_cnt <= '0;
      r_len_err <= (udp_length < 16'd8);
    end else if (w_s_acc) begin
      r_pay_cnt <= w_tot;
      r_len_err <= s_last &&
        (w_tot != (r_len - 16'd8));
    end else begin
      r_len_err <= 1'b0;
    end
  end

  assign len_err = r_len_err;
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_udp_header_inserter.sv
// Directed self-checking bench for udp_header_inserter (64- and 32-bit).
module tb_udp_header_inserter;

`ifdef UDP_TX_LEN_CHECK_EN
  localparam logic LEN_CHK = 1'b1;
`else
  localparam logic LEN_CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        hdr_valid, hdr_ready;
  logic [15:0] src_port, dst_port, udp_length, udp_checksum;
  logic [63:0] s_tdata, m_tdata;
  logic [3:0]  s_idx, m_idx;
  logic        s_last, s_valid, s_ready;
  logic        m_last, m_valid, m_ready, len_err;

  logic        h32_valid, h32_ready;
  logic [31:0] s32_tdata, m32_tdata;
  logic [2:0]  s32_idx, m32_idx;
  logic        s32_last, s32_valid, s32_ready;
  logic        m32_last, m32_valid, m32_ready, e32;

  udp_header_inserter #(.DATA_WIDTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .src_port(src_port), .dst_port(dst_port),
    .udp_length(udp_length), .udp_checksum(udp_checksum),
    .s_tdata(s_tdata), .s_idx(s_idx), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready),
    .m_tdata(m_tdata), .m_idx(m_idx), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready), .len_err(len_err)
  );

  udp_header_inserter #(.DATA_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .hdr_valid(h32_valid), .hdr_ready(h32_ready),
    .src_port(src_port), .dst_port(dst_port),
    .udp_length(udp_length), .udp_checksum(udp_checksum),
    .s_tdata(s32_tdata), .s_idx(s32_idx), .s_last(s32_last),
    .s_valid(s32_valid), .s_ready(s32_ready),
    .m_tdata(m32_tdata), .m_idx(m32_idx), .m_last(m32_last),
    .m_valid(m32_valid), .m_ready(m32_ready), .len_err(e32)
  );

  task automatic set_hdr(input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] l, input logic [15:0] c);
    src_port = s; dst_port = d; udp_length = l; udp_checksum = c;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %0b exp 0", m_valid); end
    checks++; if (m_tdata !== 64'h0) begin errors++; $display("FAIL rst_m_tdata got %h exp 0", m_tdata); end
    checks++; if (m_idx !== 4'd0 || m_last !== 1'b0) begin errors++; $display("FAIL rst_idx_last got %0d/%0b exp 0/0", m_idx, m_last); end
    checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL rst_hdr_ready got %0b exp 1", hdr_ready); end
    checks++; if (s_ready !== 1'b0 || len_err !== 1'b0) begin errors++; $display("FAIL rst_sready_lenerr got %0b/%0b exp 0/0", s_ready, len_err); end
    checks++; if (m32_valid !== 1'b0 || h32_ready !== 1'b1) begin errors++; $display("FAIL rst_32 got %0b/%0b exp 0/1", m32_valid, h32_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_one_beat(input logic [15:0] s, input logic [15:0] d,
                               input logic [63:0] exp_hdr, input logic [63:0] pay);
    @(posedge clk); #1;
    m_ready = 1'b1;
    set_hdr(s, d, 16'h0010, (s == 16'h1234) ? 16'hABCD : 16'h0000);
    hdr_valid = 1'b1;
    checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL one_hdr_ready got %0b exp 1", hdr_ready); end
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_tdata !== exp_hdr) begin errors++; $display("FAIL one_hdr_beat got %0b %h exp 1 %h", m_valid, m_tdata, exp_hdr); end
    checks++; if (m_idx !== 4'd8 || m_last !== 1'b0) begin errors++; $display("FAIL one_hdr_idx_last got %0d/%0b exp 8/0", m_idx, m_last); end
    checks++; if (hdr_ready !== 1'b0 || s_ready !== 1'b1) begin errors++; $display("FAIL one_hdr_readys got %0b/%0b exp 0/1", hdr_ready, s_ready); end
    s_valid = 1'b1; s_tdata = pay; s_idx = 4'd8; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_tdata !== pay) begin errors++; $display("FAIL one_pay_beat got %0b %h exp 1 %h", m_valid, m_tdata, pay); end
    checks++; if (m_idx !== 4'd8 || m_last !== 1'b1) begin errors++; $display("FAIL one_pay_idx_last got %0d/%0b exp 8/1", m_idx, m_last); end
    checks++; if (hdr_ready !== 1'b1) begin errors++; $display("FAIL one_end_hdr_ready got %0b exp 1", hdr_ready); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL one_drain got %0b exp 0", m_valid); end
  endtask

  task automatic test_hdr_only;
    @(posedge clk); #1;
    set_hdr(16'h1234, 16'h0050, 16'h0008, 16'hABCD);
    hdr_valid = 1'b1;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_tdata !== 64'hCDAB080050003412) begin errors++; $display("FAIL ho_beat got %0b %h exp 1 cdab080050003412", m_valid, m_tdata); end
    checks++; if (m_last !== 1'b1 || s_ready !== 1'b0 || hdr_ready !== 1'b0) begin errors++; $display("FAIL ho_flags got last %0b sr %0b hr %0b exp 1 0 0", m_last, s_ready, hdr_ready); end
    @(posedge clk); #1;
    checks++; if (hdr_ready !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin errors++; $display("FAIL ho_end got hr %0b sr %0b mv %0b exp 1 0 0", hdr_ready, s_ready, m_valid); end
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    m_ready = 1'b0;
    set_hdr(16'hA1B2, 16'hC3D4, 16'h0010, 16'h0F1E);
    hdr_valid = 1'b1;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    s_valid = 1'b1; s_tdata = 64'h0102030405060708; s_idx = 4'd8; s_last = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++; if (m_valid !== 1'b1 || m_tdata !== 64'h1E0F1000D4C3B2A1 || m_idx !== 4'd8 || m_last !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got %0b %h %0d %0b exp 1 1e0f1000d4c3b2a1 8 0", c, m_valid, m_tdata, m_idx, m_last); end
      checks++; if (hdr_ready !== 1'b0 || s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %0b/%0b exp 0/0", c, hdr_ready, s_ready); end
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_valid !== 1'b1 || m_tdata !== 64'h0102030405060708 || m_last !== 1'b1) begin errors++; $display("FAIL bp_resume got %0b %h %0b exp 1 0102030405060708 1", m_valid, m_tdata, m_last); end
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0 || hdr_ready !== 1'b1) begin errors++; $display("FAIL bp_end got %0b/%0b exp 0/1", m_valid, hdr_ready); end
  endtask

  task automatic test_len(input logic [15:0] len, input logic exp_err);
    @(posedge clk); #1;
    set_hdr(16'h0001, 16'h0002, len, 16'h0000);
    hdr_valid = 1'b1;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len%0d_hdr_err got %0b exp 0", len, len_err); end
    s_valid = 1'b1; s_tdata = 64'h0000000000CCBBAA; s_idx = 4'd3; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_idx !== 4'd3 || m_last !== 1'b1 || m_tdata !== 64'h0000000000CCBBAA) begin errors++; $display("FAIL len%0d_beat got %0d %0b %h exp 3 1 ccbbaa", len, m_idx, m_last, m_tdata); end
    checks++; if (len_err !== exp_err) begin errors++; $display("FAIL len%0d_err got %0b exp %0b", len, len_err, exp_err); end
    @(posedge clk); #1;
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len%0d_err_pulse got %0b exp 0", len, len_err); end
  endtask

  task automatic test_width32;
    @(posedge clk); #1;
    m32_ready = 1'b1;
    set_hdr(16'h1234, 16'h0050, 16'h0010, 16'hABCD);
    h32_valid = 1'b1;
    @(posedge clk); #1;
    h32_valid = 1'b0;
    checks++; if (m32_valid !== 1'b1 || m32_tdata !== 32'h50003412 || m32_idx !== 3'd4 || m32_last !== 1'b0) begin errors++; $display("FAIL w32_hdr0 got %0b %h %0d %0b exp 1 50003412 4 0", m32_valid, m32_tdata, m32_idx, m32_last); end
    checks++; if (s32_ready !== 1'b0) begin errors++; $display("FAIL w32_sready_hdr got %0b exp 0", s32_ready); end
    s32_valid = 1'b1; s32_tdata = 32'h44332211; s32_idx = 3'd4; s32_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (m32_valid !== 1'b1 || m32_tdata !== 32'hCDAB1000 || m32_idx !== 3'd4 || m32_last !== 1'b0) begin errors++; $display("FAIL w32_hdr1 got %0b %h %0d %0b exp 1 cdab1000 4 0", m32_valid, m32_tdata, m32_idx, m32_last); end
    @(posedge clk); #1;
    checks++; if (m32_valid !== 1'b1 || m32_tdata !== 32'h44332211 || m32_last !== 1'b0) begin errors++; $display("FAIL w32_pay0 got %0b %h %0b exp 1 44332211 0", m32_valid, m32_tdata, m32_last); end
    s32_tdata = 32'h88776655; s32_last = 1'b1;
    @(posedge clk); #1;
    s32_valid = 1'b0; s32_last = 1'b0;
    checks++; if (m32_tdata !== 32'h88776655 || m32_last !== 1'b1 || h32_ready !== 1'b1) begin errors++; $display("FAIL w32_pay1 got %h %0b %0b exp 88776655 1 1", m32_tdata, m32_last, h32_ready); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    set_hdr(16'h1234, 16'h0050, 16'h0018, 16'hABCD);
    hdr_valid = 1'b1;
    @(posedge clk); #1;
    hdr_valid = 1'b0;
    s_valid = 1'b1; s_tdata = 64'h1111111111111111; s_idx = 4'd8; s_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_tdata !== 64'h1111111111111111 || m_last !== 1'b0) begin errors++; $display("FAIL rm_pay0 got %h %0b exp 1111111111111111 0", m_tdata, m_last); end
    s_tdata = 64'h2222222222222222; s_last = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_valid !== 1'b0 || m_last !== 1'b0) begin errors++; $display("FAIL rm_async got %0b/%0b exp 0/0", m_valid, m_last); end
    checks++; if (hdr_ready !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL rm_state got %0b/%0b exp 1/0", hdr_ready, s_ready); end
    @(posedge clk); #1 rst_n = 1'b1;
    test_one_beat(16'hBEEF, 16'h0035, 64'h000010003500EFBE, 64'h0A0B0C0D0E0F1011);
  endtask

  initial begin
    hdr_valid = 1'b0; m_ready = 1'b1;
    s_valid = 1'b0; s_last = 1'b0; s_idx = '0; s_tdata = '0;
    h32_valid = 1'b0; m32_ready = 1'b1;
    s32_valid = 1'b0; s32_last = 1'b0; s32_idx = '0; s32_tdata = '0;
    set_hdr(16'h0, 16'h0, 16'h0, 16'h0);
    test_reset;
    test_one_beat(16'h1234, 16'h0050, 64'hCDAB100050003412, 64'h8877665544332211);
    test_hdr_only;
    test_backpressure;
    test_len(16'd11, 1'b0);
    test_len(16'd12, LEN_CHK);
    test_width32;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_header_inserter.md
# udp_header_inserter

Transmit-side UDP encapsulation stage. It accepts one UDP header descriptor per datagram and serializes the 8-byte UDP header onto the outgoing byte-lane beat stream. It then passes the datagram payload through behind the header. It sits between the TX payload source and the IPv4 header inserter, and is the egress counterpart of the RX UDP/TCP header parser: same lane order, same `idx` byte-count convention.

## Interface
Parameters:
- `DATA_WIDTH`, default 64. Beat width in bits. Legal values are 32 and 64 only; the header occupies exactly 8/(DATA_WIDTH/8) beats.
- `IDX_W`, default $clog2(DATA_WIDTH/8+1). Width of the byte-count fields.

Ports:
- `clk`  in  1  Clock.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `hdr_valid`  in  1  Header descriptor valid.
- `hdr_ready`  out  1  Descriptor accepted when `hdr_valid` and `hdr_ready` are both high.
- `src_port`  in  16  UDP source port.
- `dst_port`  in  16  UDP destination port.
- `udp_length`  in  16  UDP length field, header plus payload, in bytes.
- `udp_checksum`  in  16  UDP checksum field, inserted verbatim.
- `s_tdata`  in  DATA_WIDTH  Payload beat. Byte i is at [i*8 +: 8]; lane 0 is first on the wire.
- `s_idx`  in  IDX_W  Count of valid payload bytes, packed from lane 0.
- `s_last`  in  1  Final payload beat.
- `s_valid`  in  1  Payload beat valid.
- `s_ready`  out  1  Payload beat accepted when `s_valid` and `s_ready` are both high.
- `m_tdata`  out  DATA_WIDTH  Output beat.
- `m_idx`  out  IDX_W  Output valid byte count.
- `m_last`  out  1  Final beat of the datagram.
- `m_valid`  out  1  Output beat valid.
- `m_ready`  in  1  Downstream accept.
- `len_err`  out  1  One-cycle length-mismatch pulse. Present only with `UDP_TX_LEN_CHECK_EN`.

## Operation
- FSM states are IDLE, HDR and PAYLOAD.
- **IDLE**
  - `hdr_ready` = 1 and `s_ready` = 0.
  - On `hdr_valid` the four fields are registered, the header beat counter is cleared and the FSM goes to HDR.
- **HDR**
  - The output register is loaded with header beat k. Header bytes in wire order are src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], cks[15:8], cks[7:0].
  - Header beats carry `m_idx` = DATA_WIDTH/8.
  - The counter advances when the register is free, i.e. `!m_valid || m_ready`.
  - After the final header beat:
    - If `udp_length` <= 8, that beat carries `m_last` = 1 and the FSM returns to IDLE.
    - Otherwise the FSM goes to PAYLOAD.
- **PAYLOAD**
  - `s_ready` = `!m_valid || m_ready`.
  - Each accepted beat is copied unchanged (`tdata`, `idx`, `last`) into the output register.
  - Accepting a beat with `s_last` = 1 returns the FSM to IDLE.
  - A beat with `s_idx` = 0 and `s_last` = 1 is forwarded as is.
- Descriptor fields must not change while `hdr_valid` is high and `hdr_ready` is low. `hdr_ready` is low throughout HDR and PAYLOAD.
- The output register holds `m_tdata`, `m_idx` and `m_last` stable while `m_valid` && !`m_ready`.
- Payload byte order is never realigned; the header always fills whole beats.

## Timing
- Reset values:
  - `m_valid`, `m_tdata`, `m_idx`, `m_last`, `s_ready` and `len_err` are 0.
  - `hdr_ready` is 1, because the FSM resets to IDLE.
- Latency:
  - Descriptor accepted in cycle N; first header beat has `m_valid` = 1 in cycle N+1.
  - Payload beat accepted in cycle M appears on `m_*` in cycle M+1.
- Throughput is one beat per cycle with `m_ready` held high. There are no bubbles between the header and the payload.
- `hdr_ready` rises the cycle after the datagram's last beat is loaded into the output register. It does not wait for that beat to drain.
- Reset asserted mid-datagram returns all state to reset values asynchronously. The partial frame is truncated and `m_valid` drops with no `m_last`.

## Configuration
- Macro `UDP_TX_LEN_CHECK_EN`.
- **Defined:**
  - A 16-bit counter sums `s_idx` over accepted payload beats. It saturates at 0xFFFF and is cleared on descriptor accept.
  - When the `s_last` beat is accepted, the total including that beat is compared with `udp_length` - 8.
  - On mismatch, `len_err` pulses high in the following cycle.
  - `udp_length` < 8 pulses `len_err` in the cycle after descriptor accept.
  - Data is always forwarded unmodified.
- **Undefined:** the counter is not built and `len_err` is tied 0.

## Structure
- Package `udp_tx_pkg` holds:
  - the state enum `udp_tx_state_t`;
  - `UDP_HDR_BYTES` = 8 and `IP_PROTO_UDP` = 17;
  - the function `udp_hdr_byte(idx, src, dst, len, cks)` returning header byte idx.
- No sub-module. The output register and FSM are inline.

## Test plan
All scenarios use DATA_WIDTH = 64 unless stated.
- **Header plus one payload beat.** src 0x1234, dst 0x0050, len 0x0010, cks 0xABCD, then one payload beat 0x8877665544332211 with idx 8 and last.
  - Beat 1: `m_tdata` = 0xCDAB100050003412, idx 8, last 0.
  - Beat 2: payload unchanged, idx 8, last 1.
  - No gap between the beats.
- **Header only.** len 0x0008.
  - Single header beat with `m_last` = 1.
  - `s_ready` never asserts.
  - `hdr_ready` returns high two cycles after accept.
- **Backpressure.** `m_ready` held low for 3 cycles during the header beat.
  - `m_tdata`, `m_idx` and `m_last` stay stable.
  - `hdr_ready` and `s_ready` stay 0.
  - The stream resumes without byte loss.
- **Length check.** Payload of 3 bytes (idx 3, last) with len 11: `m_idx` = 3, `m_last` = 1, `len_err` = 0. With len 12 and `UDP_TX_LEN_CHECK_EN` defined, `len_err` pulses one cycle after the last beat is accepted.
- **32-bit width.** DATA_WIDTH = 32, same fields as the first scenario.
  - Header beats are 0x50003412 then 0xCDAB1000, each with idx 4.
- **Reset mid-payload.** `rst_n` driven low during the second payload beat.
  - `m_valid` is 0 immediately.
  - After release, `hdr_ready` = 1 and a new datagram is emitted correctly.
